mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 152 +++++++++++++++
 tb/tb_mem_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage driving a req/gnt/rvalid data-memory port with
// alignment and timeout checks in front of the MEM/WB register.
module mem_stage #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        MemToRegM,
    input  logic        MemReadM,
    input  logic [4:0]  RD_M,
    input  logic [63:0] WriteDataM,
    input  logic [63:0] ALU_ResultM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [63:0] dmem_rdata,
    output logic        StallM,
    output logic        RegWriteW,
    output logic        MemToRegW,
    output logic [4:0]  RD_W,
    output logic [63:0] ReadDataW,
    output logic [63:0] ALU_ResultW,
    output logic        MisalignW,
    output logic        TimeoutW
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   wait_cnt, wait_cnt_nx;
    logic            mem_op, aligned, expire, issue, req_clear;
    logic            wb_rw, wb_m2r, wb_mis, wb_to;
    logic [4:0]      wb_rd;
    logic [63:0]     wb_alu, wb_rdata;

    assign mem_op  = MemReadM | MemWriteM;
    assign aligned = ALU_ResultM[2:0] == 3'd0;
    assign expire  = wait_cnt == CW'(MAX_WAIT - 1);

    always_comb begin
        state_nx    = state;
        wait_cnt_nx = '0;
        StallM      = 1'b0;
        issue       = 1'b0;
        req_clear   = 1'b0;
        wb_rw       = RegWriteM;
        wb_m2r      = MemToRegM;
        wb_rd       = RD_M;
        wb_alu      = ALU_ResultM;
        wb_rdata    = '0;
        wb_mis      = 1'b0;
        wb_to       = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op && aligned) begin
                    StallM   = 1'b1;
                    issue    = 1'b1;
                    state_nx = REQ;
                end else if (mem_op) begin
                    wb_rw  = 1'b0;
                    wb_m2r = 1'b0;
                    wb_mis = 1'b1;
                end
            end
            REQ: begin
                // a granted store completes immediately; a granted load still waits for data
                if (dmem_gnt && dmem_we) begin
                    state_nx  = IDLE;
                    req_clear = 1'b1;
                end else if (expire) begin
                    state_nx  = IDLE;
                    req_clear = 1'b1;
                    wb_rw     = 1'b0;
                    wb_m2r    = 1'b0;
                    wb_to     = 1'b1;
                end else begin
                    StallM      = 1'b1;
                    wait_cnt_nx = wait_cnt + 1'b1;
                    state_nx    = dmem_gnt ? WAIT : REQ;
                    req_clear   = dmem_gnt;
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    state_nx = IDLE;
                    wb_rdata = dmem_rdata;
                end else if (expire) begin
                    state_nx = IDLE;
                    wb_rw    = 1'b0;
                    wb_m2r   = 1'b0;
                    wb_to    = 1'b1;
                end else begin
                    StallM      = 1'b1;
                    wait_cnt_nx = wait_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (StallM) begin
            wb_rw    = 1'b0;
            wb_m2r   = 1'b0;
            wb_rd    = '0;
            wb_alu   = '0;
            wb_rdata = '0;
            wb_mis   = 1'b0;
            wb_to    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            RegWriteW   <= 1'b0;
            MemToRegW   <= 1'b0;
            RD_W        <= '0;
            ReadDataW   <= '0;
            ALU_ResultW <= '0;
            MisalignW   <= 1'b0;
            TimeoutW    <= 1'b0;
        end else begin
            state       <= state_nx;
            wait_cnt    <= wait_cnt_nx;
            if (issue) begin
                dmem_req   <= 1'b1;
                dmem_we    <= MemWriteM & ~MemReadM;
                dmem_addr  <= ALU_ResultM;
                dmem_wdata <= WriteDataM;
            end else if (req_clear) begin
                dmem_req <= 1'b0;
                dmem_we  <= 1'b0;
            end
            RegWriteW   <= wb_rw;
            MemToRegW   <= wb_m2r;
            RD_W        <= wb_rd;
            ReadDataW   <= wb_rdata;
            ALU_ResultW <= wb_alu;
            MisalignW   <= wb_mis;
            TimeoutW    <= wb_to;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed checks of mem_stage against a
// transaction-level latency/outcome model.
module tb_mem_stage;
    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        RegWriteM = 1'b0, MemWriteM = 1'b0, MemToRegM = 1'b0, MemReadM = 1'b0;
    logic [4:0]  RD_M = '0;
    logic [63:0] WriteDataM = '0, ALU_ResultM = '0;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [63:0] dmem_rdata = '0;
    logic        StallM, RegWriteW, MemToRegW, MisalignW, TimeoutW;
    logic [4:0]  RD_W;
    logic [63:0] ReadDataW, ALU_ResultW;

    int checks = 0;
    int errors = 0;

    mem_stage #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemToRegM(MemToRegM), .MemReadM(MemReadM),
        .RD_M(RD_M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .StallM(StallM),
        .RegWriteW(RegWriteW), .MemToRegW(MemToRegW), .RD_W(RD_W),
        .ReadDataW(ReadDataW), .ALU_ResultW(ALU_ResultW),
        .MisalignW(MisalignW), .TimeoutW(TimeoutW)
    );

    always #5 clk = ~clk;

    // One instruction through the stage: g = REQ cycles without grant before the
    // grant, r = WAIT cycle on which read data returns (1 = right after grant).
    // Starts and ends at posedge+1.
    task automatic run_op(input string name, input logic rw, mw, m2r, mr,
                          input logic [4:0] rd, input logic [63:0] wd, a,
                          input int g, r, input logic [63:0] rdata);
        logic mem, al, st, ld, tmo, ok;
        int n, endc, reqend;
        logic [136:0] exp_wb, act_wb;
        mem    = mr | mw;
        al     = a[2:0] == 3'd0;
        st     = mw & ~mr;
        ld     = mem & al & ~st;
        n      = st ? g + 1 : g + 1 + r;
        tmo    = mem && al && n > MAX_WAIT;
        endc   = (mem && al) ? (tmo ? MAX_WAIT : n) : 0;
        reqend = (mem && al) ? ((g + 1 < endc) ? g + 1 : endc) : 0;
        ok     = !mem || (al && !tmo);
        exp_wb = {ok & rw, ok & m2r, rd, a, (ld && !tmo) ? rdata : 64'd0, mem & ~al, tmo};
        for (int c = 0; c <= endc; c++) begin
            if (c >= 1) begin
                checks++;
                if ({RegWriteW, MemToRegW, RD_W, MisalignW, TimeoutW} !== 9'd0) begin
                    errors++;
                    $display("FAIL %s bubble c=%0d got rw=%b m2r=%b rd=%0d mis=%b to=%b want all 0",
                             name, c, RegWriteW, MemToRegW, RD_W, MisalignW, TimeoutW);
                end
            end
            if (c == 0) begin
                RegWriteM = rw; MemWriteM = mw; MemToRegM = m2r; MemReadM = mr;
                RD_M = rd; WriteDataM = wd; ALU_ResultM = a;
            end
            dmem_gnt    = (mem && al && c == g + 1) ? 1'b1 :
                          (c == 0 || c > g + 1) ? 1'($urandom % 2) : 1'b0;
            dmem_rvalid = (ld && c == g + 1 + r) ? 1'b1 :
                          (c <= g + 1) ? 1'($urandom % 2) : 1'b0;
            dmem_rdata  = (c == g + 1 + r) ? rdata : {$urandom, $urandom};
            @(negedge clk);
            checks++;
            if (StallM !== (c != endc)) begin
                errors++;
                $display("FAIL %s stall c=%0d got %b want %b", name, c, StallM, c != endc);
            end
            checks++;
            if (dmem_req !== (c >= 1 && c <= reqend) || dmem_we !== (c >= 1 && c <= reqend && st)) begin
                errors++;
                $display("FAIL %s req/we c=%0d got %b/%b want %b/%b", name, c, dmem_req, dmem_we,
                         c >= 1 && c <= reqend, c >= 1 && c <= reqend && st);
            end
            if (c >= 1 && c <= reqend) begin
                checks++;
                if (dmem_addr !== a || dmem_wdata !== wd) begin
                    errors++;
                    $display("FAIL %s addr/wdata c=%0d got %h/%h want %h/%h", name, c, dmem_addr, dmem_wdata, a, wd);
                end
            end
            @(posedge clk);
            #1;
        end
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
        act_wb = {RegWriteW, MemToRegW, RD_W, ALU_ResultW, ReadDataW, MisalignW, TimeoutW};
        checks++;
        if (act_wb !== exp_wb || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s wb got %h req=%b want %h req=0", name, act_wb, dmem_req, exp_wb);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        RegWriteM = 1'b1; MemReadM = 1'b1; MemToRegM = 1'b1; ALU_ResultM = 64'h40; RD_M = 5'd3;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 64'h55;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, RegWriteW, MemToRegW, RD_W, ReadDataW,
             ALU_ResultW, MisalignW, TimeoutW} !== '0) begin
            errors++;
            $display("FAIL reset regs got req=%b we=%b rw=%b rd=%0d alu=%h want all 0",
                     dmem_req, dmem_we, RegWriteW, RD_W, ALU_ResultW);
        end
        RegWriteM = 1'b0; MemReadM = 1'b0; MemToRegM = 1'b0; ALU_ResultM = '0; RD_M = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (StallM !== 1'b0) begin
            errors++;
            $display("FAIL reset stall got %b want 0", StallM);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_alu();
        run_op("alu", 1, 0, 0, 0, 5'd5, 64'd0, 64'h2A, 0, 0, 64'd0);
    endtask

    task automatic test_store();
        run_op("store", 0, 1, 0, 0, 5'd0, 64'hDEADBEEF, 64'h100, 0, 0, 64'd0);
    endtask

    task automatic test_load();
        run_op("load", 1, 0, 1, 1, 5'd7, 64'd0, 64'h200, 1, 3, 64'h1234);
    endtask

    task automatic test_misalign();
        run_op("misalign", 1, 0, 1, 1, 5'd7, 64'd0, 64'h203, 0, 1, 64'd0);
    endtask

    task automatic test_timeout();
        run_op("timeout", 1, 0, 1, 1, 5'd9, 64'd0, 64'h300, 40, 1, 64'd0);
        run_op("store_last", 0, 1, 0, 0, 5'd1, 64'h77, 64'h308, MAX_WAIT - 1, 0, 64'd0);
        run_op("load_last", 1, 0, 1, 1, 5'd2, 64'd0, 64'h310, MAX_WAIT - 2, 1, 64'hABCD);
        run_op("load_late_gnt", 1, 0, 1, 1, 5'd3, 64'd0, 64'h318, MAX_WAIT - 1, 1, 64'hBEEF);
        run_op("both_rd_wr", 1, 1, 1, 1, 5'd4, 64'h99, 64'h320, 0, 2, 64'h4242);
    endtask

    task automatic test_reset_mid();
        RegWriteM = 1'b1; MemReadM = 1'b1; MemToRegM = 1'b1; MemWriteM = 1'b0;
        RD_M = 5'd6; ALU_ResultM = 64'h400;
        @(posedge clk);
        #1;
        dmem_gnt = 1'b1;
        @(posedge clk);
        #1;
        dmem_gnt = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        RegWriteM = 1'b0; MemReadM = 1'b0; MemToRegM = 1'b0; RD_M = '0; ALU_ResultM = '0;
        checks++;
        if ({dmem_req, RegWriteW, MemToRegW, RD_W, ReadDataW, TimeoutW} !== '0) begin
            errors++;
            $display("FAIL reset_mid regs got req=%b rw=%b m2r=%b rd=%0d rdata=%h to=%b want all 0",
                     dmem_req, RegWriteW, MemToRegW, RD_W, ReadDataW, TimeoutW);
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = 64'hFEED;
        @(negedge clk);
        checks++;
        if (StallM !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid stall got %b want 0", StallM);
        end
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b0;
        checks++;
        if ({RegWriteW, MemToRegW, ReadDataW, dmem_req} !== '0) begin
            errors++;
            $display("FAIL reset_mid late_rvalid got rw=%b m2r=%b rdata=%h req=%b want all 0",
                     RegWriteW, MemToRegW, ReadDataW, dmem_req);
        end
        run_op("alu_after_reset", 1, 0, 0, 0, 5'd12, 64'd0, 64'h1234_5678, 0, 0, 64'd0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic [63:0] a;
            a = {$urandom, $urandom};
            if ($urandom % 4 != 0) a[2:0] = 3'd0;
            run_op("random", 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2),
                   5'($urandom_range(0, 31)), {$urandom, $urandom}, a,
                   $urandom_range(0, 16), $urandom_range(1, 5), {$urandom, $urandom});
        end
    endtask

    task automatic test_back_to_back();
        run_op("b2b_store", 0, 1, 0, 0, 5'd8, 64'h11, 64'h500, 0, 0, 64'd0);
        run_op("b2b_load", 1, 0, 1, 1, 5'd9, 64'd0, 64'h508, 0, 1, 64'h22);
        run_op("b2b_alu", 1, 0, 0, 0, 5'd10, 64'd0, 64'h33, 0, 0, 64'd0);
        run_op("b2b_mis", 0, 1, 0, 0, 5'd11, 64'h44, 64'h511, 0, 0, 64'd0);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store();
        test_load();
        test_misalign();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
